// File: rtl/hazard_detection_unit.sv
// Pipeline hazard detection: load-use stall and taken-branch flush control,
// plus saturating event counters for both conditions.
module hazard_detection_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  opcode_ifid,
    input  logic [3:0]  Rn_ifid,
    input  logic [3:0]  Rm_ifid,
    input  logic [4:0]  opcode_idex,
    input  logic [3:0]  Rd_idex,
    input  logic        mem_read_en_idex,
    input  logic        branch_taken_exmem,
    output logic        pc_write_en,
    output logic        if_id_write_en,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    logic        load_use;
    logic        branch;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    // Opcodes are reserved for future decode; both sources are always compared.
    logic unused_opcodes;
    assign unused_opcodes = ^{opcode_ifid, opcode_idex};

    // R0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = mem_read_en_idex && (Rd_idex != 4'd0) &&
                      ((Rd_idex == Rn_ifid) || (Rd_idex == Rm_ifid));
    assign branch   = branch_taken_exmem;

    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        if (!rst_n) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
            ex_mem_flush   = 1'b1;
        end else if (branch) begin
            // Branch wins: the PC loads the target and younger stages are squashed.
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
            ex_mem_flush   = 1'b1;
        end else if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (load_use && !branch && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        if (branch && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed scenarios plus
// randomized traffic compared against a rule-level reference model.
module tb_hazard_detection_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  opcode_ifid;
    logic [3:0]  Rn_ifid;
    logic [3:0]  Rm_ifid;
    logic [4:0]  opcode_idex;
    logic [3:0]  Rd_idex;
    logic        mem_read_en_idex;
    logic        branch_taken_exmem;
    logic        pc_write_en;
    logic        if_id_write_en;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int checks = 0;
    int errors = 0;
    int m_stall = 0;
    int m_flush = 0;

    logic [3:0] ctrl;
    assign ctrl = {pc_write_en, if_id_write_en, id_ex_flush, ex_mem_flush};

    always #5 clk = ~clk;

    hazard_detection_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .opcode_ifid        (opcode_ifid),
        .Rn_ifid            (Rn_ifid),
        .Rm_ifid            (Rm_ifid),
        .opcode_idex        (opcode_idex),
        .Rd_idex            (Rd_idex),
        .mem_read_en_idex   (mem_read_en_idex),
        .branch_taken_exmem (branch_taken_exmem),
        .pc_write_en        (pc_write_en),
        .if_id_write_en     (if_id_write_en),
        .id_ex_flush        (id_ex_flush),
        .ex_mem_flush       (ex_mem_flush),
        .stall_count        (stall_count),
        .flush_count        (flush_count)
    );

    // Reference: is the ID/EX load's result needed by the IF/ID instruction?
    function automatic bit ref_load_use();
        return mem_read_en_idex && Rd_idex != 0 &&
               (Rd_idex == Rn_ifid || Rd_idex == Rm_ifid);
    endfunction

    // Expected {pc_write_en, if_id_write_en, id_ex_flush, ex_mem_flush}.
    function automatic logic [3:0] ref_ctrl();
        if (!rst_n)              return 4'b0011;
        if (branch_taken_exmem)  return 4'b1011;
        if (ref_load_use())      return 4'b0010;
        return 4'b1100;
    endfunction

    task automatic apply(input bit rst, input int rn, input int rm, input int rd,
                         input bit mr, input bit br);
        @(negedge clk);
        rst_n              = rst;
        Rn_ifid            = 4'(rn);
        Rm_ifid            = 4'(rm);
        Rd_idex            = 4'(rd);
        mem_read_en_idex   = mr;
        branch_taken_exmem = br;
        opcode_ifid        = 5'($urandom);
        opcode_idex        = 5'($urandom);
        #1;
    endtask

    // Advance one clock and update the model counters from the held inputs.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (ref_load_use() && !branch_taken_exmem && m_stall < 65535) m_stall++;
            if (branch_taken_exmem && m_flush < 65535) m_flush++;
        end
        #1;
    endtask

    task automatic test_reset();
        apply(0, 5, 5, 5, 1, 0);
        checks++;
        if (ctrl !== 4'b0011) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0011", ctrl);
        end
        tick();
        checks++;
        if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts got %0d/%0d want 0/0", stall_count, flush_count);
        end
    endtask

    task automatic test_normal();
        apply(1, 1, 2, 3, 0, 0);
        checks++;
        if (ctrl !== 4'b1100) begin
            errors++;
            $display("FAIL normal_ctrl got %b want 1100", ctrl);
        end
        tick();
        tick();
        checks++;
        if (stall_count !== 16'(m_stall) || flush_count !== 16'(m_flush)) begin
            errors++;
            $display("FAIL normal_counts got %0d/%0d want %0d/%0d",
                     stall_count, flush_count, m_stall, m_flush);
        end
    endtask

    task automatic test_load_use();
        apply(1, 1, 3, 1, 1, 0);
        checks++;
        if (ctrl !== 4'b0010) begin
            errors++;
            $display("FAIL load_use_rn_ctrl got %b want 0010", ctrl);
        end
        repeat (3) tick();
        checks++;
        if (stall_count !== 16'd3) begin
            errors++;
            $display("FAIL load_use_rn_count got %0d want 3", stall_count);
        end
        apply(1, 3, 1, 1, 1, 0);
        checks++;
        if (ctrl !== 4'b0010) begin
            errors++;
            $display("FAIL load_use_rm_ctrl got %b want 0010", ctrl);
        end
        tick();
        checks++;
        if (stall_count !== 16'd4) begin
            errors++;
            $display("FAIL load_use_rm_count got %0d want 4", stall_count);
        end
    endtask

    task automatic test_branch();
        apply(1, 1, 2, 3, 0, 1);
        checks++;
        if (ctrl !== 4'b1011) begin
            errors++;
            $display("FAIL branch_ctrl got %b want 1011", ctrl);
        end
        tick();
        checks++;
        if (flush_count !== 16'd1 || stall_count !== 16'd4) begin
            errors++;
            $display("FAIL branch_counts got %0d/%0d want 4/1", stall_count, flush_count);
        end
        apply(1, 1, 3, 1, 1, 1);
        checks++;
        if (ctrl !== 4'b1011) begin
            errors++;
            $display("FAIL branch_lu_ctrl got %b want 1011", ctrl);
        end
        tick();
        checks++;
        if (flush_count !== 16'd2 || stall_count !== 16'd4) begin
            errors++;
            $display("FAIL branch_lu_counts got %0d/%0d want 4/2", stall_count, flush_count);
        end
    endtask

    task automatic test_r0();
        apply(1, 1, 2, 0, 1, 0);
        checks++;
        if (ctrl !== 4'b1100) begin
            errors++;
            $display("FAIL r0_ctrl got %b want 1100", ctrl);
        end
        tick();
        apply(1, 0, 0, 0, 1, 0);
        checks++;
        if (ctrl !== 4'b1100) begin
            errors++;
            $display("FAIL r0_both_ctrl got %b want 1100", ctrl);
        end
        tick();
        checks++;
        if (stall_count !== 16'd4) begin
            errors++;
            $display("FAIL r0_count got %0d want 4", stall_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            apply($urandom_range(19, 0) != 0, $urandom_range(3, 0), $urandom_range(3, 0),
                  $urandom_range(3, 0), 1'($urandom), $urandom_range(3, 0) == 0);
            checks++;
            if (ctrl !== ref_ctrl()) begin
                errors++;
                $display("FAIL random_ctrl[%0d] got %b want %b", i, ctrl, ref_ctrl());
            end
            tick();
            checks++;
            if (stall_count !== 16'(m_stall) || flush_count !== 16'(m_flush)) begin
                errors++;
                $display("FAIL random_counts[%0d] got %0d/%0d want %0d/%0d",
                         i, stall_count, flush_count, m_stall, m_flush);
            end
        end
    endtask

    task automatic test_reset_midstream();
        apply(1, 2, 2, 2, 1, 0);
        tick();
        apply(0, 2, 2, 2, 1, 1);
        checks++;
        if (ctrl !== 4'b0011) begin
            errors++;
            $display("FAIL mid_reset_ctrl got %b want 0011", ctrl);
        end
        tick();
        checks++;
        if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_counts got %0d/%0d want 0/0", stall_count, flush_count);
        end
        apply(1, 2, 2, 2, 1, 0);
        checks++;
        if (ctrl !== 4'b0010) begin
            errors++;
            $display("FAIL post_reset_ctrl got %b want 0010", ctrl);
        end
        tick();
        checks++;
        if (stall_count !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_count got %0d want 1", stall_count);
        end
    endtask

    task automatic test_saturation();
        apply(0, 0, 0, 0, 0, 0);
        tick();
        apply(1, 1, 3, 1, 1, 0);
        repeat (65534) @(posedge clk);
        #1;
        checks++;
        if (stall_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_near got %h want fffe", stall_count);
        end
        m_stall = 65534;
        m_flush = 0;
        tick();
        checks++;
        if (stall_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach got %h want ffff", stall_count);
        end
        tick();
        tick();
        checks++;
        if (stall_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold got %h want ffff", stall_count);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_load_use();
        test_branch();
        test_r0();
        test_random();
        test_reset_midstream();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
